// File: rtl/uart_ex_bus.sv
// XT high-speed bus UART slave: programmable divider, 7/8-bit frames with optional parity,
// 1/2 stop bits, RX/TX FIFOs, sticky error flags and masked level interrupts.
module uart_ex_bus #(
  parameter int OVER_SAMPLING = 16,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = '0
) (
  input  logic        hb_clk,
  input  logic        hb_rst_n,
  input  logic [31:0] xt_hb_raddr,
  input  logic [31:0] xt_hb_waddr,
  input  logic [31:0] xt_hb_wdata,
  input  logic        sel_ren,
  input  logic        sel_wen,
  output logic [31:0] rdata,
  output logic        rx_irq,
  output logic        tx_irq,
  output logic        err_irq,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int CNT_W = $clog2(OVER_SAMPLING);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_SAMPLING - 1);
  localparam logic [CNT_W-1:0] VOTE_A   = CNT_W'(OVER_SAMPLING/2 - 1);
  localparam logic [CNT_W-1:0] VOTE_B   = CNT_W'(OVER_SAMPLING/2);
  localparam logic [CNT_W-1:0] VOTE_C   = CNT_W'(OVER_SAMPLING/2 + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- bus decode and configuration ----------------
  logic [3:0] wr_idx, rd_idx;
  logic wr_data, wr_status, wr_ctrl, wr_baud, rd_data;
  logic [6:0] ctrl_reg;
  logic [DIV_WIDTH-1:0] baud_div_reg, div_cnt_reg;
  logic tick;
  logic unused_bits;

  assign wr_idx    = xt_hb_waddr[5:2];
  assign rd_idx    = xt_hb_raddr[5:2];
  assign wr_data   = sel_wen && (wr_idx == 4'd0);
  assign wr_status = sel_wen && (wr_idx == 4'd1);
  assign wr_ctrl   = sel_wen && (wr_idx == 4'd2);
  assign wr_baud   = sel_wen && (wr_idx == 4'd3);
  assign rd_data   = sel_ren && (rd_idx == 4'd0);
  assign unused_bits = ^{xt_hb_raddr[31:6], xt_hb_raddr[1:0], xt_hb_waddr[31:6],
                         xt_hb_waddr[1:0], xt_hb_wdata};

  assign tick = (div_cnt_reg == baud_div_reg);

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      ctrl_reg     <= '0;
      baud_div_reg <= DIV_RESET;
      div_cnt_reg  <= '0;
    end else begin
      if (wr_ctrl) ctrl_reg <= xt_hb_wdata[6:0];
      if (wr_baud) baud_div_reg <= xt_hb_wdata[DIV_WIDTH-1:0];
      if (wr_baud || tick) div_cnt_reg <= '0;
      else div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // ---------------- FIFOs (pointers carry one wrap bit) ----------------
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [RX_AW:0] rx_wptr_reg, rx_rptr_reg;
  logic [TX_AW:0] tx_wptr_reg, tx_rptr_reg;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_push_ok, rx_ovr_evt;
  logic tx_pop, tx_push_ok, tx_ovf_evt;
  logic [7:0] rx_byte, tx_byte;

  assign rx_empty = (rx_wptr_reg == rx_rptr_reg);
  assign rx_full  = (rx_wptr_reg[RX_AW] != rx_rptr_reg[RX_AW]) &&
                    (rx_wptr_reg[RX_AW-1:0] == rx_rptr_reg[RX_AW-1:0]);
  assign tx_empty = (tx_wptr_reg == tx_rptr_reg);
  assign tx_full  = (tx_wptr_reg[TX_AW] != tx_rptr_reg[TX_AW]) &&
                    (tx_wptr_reg[TX_AW-1:0] == tx_rptr_reg[TX_AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign rx_pop     = rd_data && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign rx_ovr_evt = rx_push && rx_full && !rx_pop;
  assign tx_push_ok = wr_data && (!tx_full || tx_pop);
  assign tx_ovf_evt = wr_data && tx_full && !tx_pop;
  assign tx_byte    = tx_mem[tx_rptr_reg[TX_AW-1:0]];

  always_ff @(posedge hb_clk) begin
    if (rx_push_ok) rx_mem[rx_wptr_reg[RX_AW-1:0]] <= rx_byte;
    if (tx_push_ok) tx_mem[tx_wptr_reg[TX_AW-1:0]] <= xt_hb_wdata[7:0];
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      rx_wptr_reg <= '0;
      rx_rptr_reg <= '0;
      tx_wptr_reg <= '0;
      tx_rptr_reg <= '0;
    end else begin
      if (rx_push_ok) rx_wptr_reg <= rx_wptr_reg + 1'b1;
      if (rx_pop)     rx_rptr_reg <= rx_rptr_reg + 1'b1;
      if (tx_push_ok) tx_wptr_reg <= tx_wptr_reg + 1'b1;
      if (tx_pop)     tx_rptr_reg <= tx_rptr_reg + 1'b1;
    end
  end

  // ---------------- RX engine ----------------
  logic rx_meta_reg, rx_sync_reg, rx_last_reg;
  state_t rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0] rx_idx_reg, rx_idx_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic rx_par_reg, rx_par_next, rx_s0_reg, rx_s0_next, rx_s1_reg, rx_s1_next;
  logic rx_bits7_reg, rx_bits7_next, rx_par_en_reg, rx_par_en_next, rx_par_odd_reg, rx_par_odd_next;
  logic rx_vote, rx_mid, rx_end, perr_evt, ferr_evt;

  assign rx_vote = (rx_s0_reg & rx_s1_reg) | (rx_s0_reg & rx_sync_reg) | (rx_s1_reg & rx_sync_reg);
  assign rx_mid  = (rx_cnt_reg == VOTE_C);
  assign rx_end  = (rx_cnt_reg == CNT_LAST);
  assign rx_byte = rx_shift_reg;

  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_cnt_next     = rx_cnt_reg;
    rx_idx_next     = rx_idx_reg;
    rx_shift_next   = rx_shift_reg;
    rx_par_next     = rx_par_reg;
    rx_s0_next      = rx_s0_reg;
    rx_s1_next      = rx_s1_reg;
    rx_bits7_next   = rx_bits7_reg;
    rx_par_en_next  = rx_par_en_reg;
    rx_par_odd_next = rx_par_odd_reg;
    rx_push  = 1'b0;
    perr_evt = 1'b0;
    ferr_evt = 1'b0;
    if (tick) begin
      if (rx_state_reg != S_IDLE) rx_cnt_next = rx_end ? '0 : rx_cnt_reg + 1'b1;
      if (rx_cnt_reg == VOTE_A) rx_s0_next = rx_sync_reg;
      if (rx_cnt_reg == VOTE_B) rx_s1_next = rx_sync_reg;
      case (rx_state_reg)
        S_IDLE: if (rx_last_reg && !rx_sync_reg) begin
          // The tick that sees the edge is sample 0 of the start bit.
          rx_state_next   = S_START;
          rx_cnt_next     = CNT_W'(1);
          rx_idx_next     = '0;
          rx_shift_next   = '0;
          rx_par_next     = 1'b0;
          rx_bits7_next   = ctrl_reg[0];
          rx_par_en_next  = ctrl_reg[1];
          rx_par_odd_next = ctrl_reg[2];
        end
        S_START: begin
          if (rx_mid && rx_vote) rx_state_next = S_IDLE;
          else if (rx_end) rx_state_next = S_DATA;
        end
        S_DATA: begin
          if (rx_mid) begin
            rx_shift_next[rx_idx_reg] = rx_vote;
            rx_par_next = rx_par_reg ^ rx_vote;
          end
          if (rx_end) begin
            if (rx_idx_reg == (rx_bits7_reg ? 3'd6 : 3'd7))
              rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
            else
              rx_idx_next = rx_idx_reg + 1'b1;
          end
        end
        S_PARITY: begin
          if (rx_mid) perr_evt = ((rx_par_reg ^ rx_vote) != rx_par_odd_reg);
          if (rx_end) rx_state_next = S_STOP;
        end
        S_STOP: if (rx_mid) begin
          ferr_evt      = !rx_vote;
          rx_push       = 1'b1;
          rx_state_next = S_IDLE;
        end
        default: rx_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_last_reg    <= 1'b1;
      rx_state_reg   <= S_IDLE;
      rx_cnt_reg     <= '0;
      rx_idx_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_reg     <= 1'b0;
      rx_s0_reg      <= 1'b1;
      rx_s1_reg      <= 1'b1;
      rx_bits7_reg   <= 1'b0;
      rx_par_en_reg  <= 1'b0;
      rx_par_odd_reg <= 1'b0;
    end else begin
      rx_meta_reg    <= uart_rx;
      rx_sync_reg    <= rx_meta_reg;
      if (tick) rx_last_reg <= rx_sync_reg;
      rx_state_reg   <= rx_state_next;
      rx_cnt_reg     <= rx_cnt_next;
      rx_idx_reg     <= rx_idx_next;
      rx_shift_reg   <= rx_shift_next;
      rx_par_reg     <= rx_par_next;
      rx_s0_reg      <= rx_s0_next;
      rx_s1_reg      <= rx_s1_next;
      rx_bits7_reg   <= rx_bits7_next;
      rx_par_en_reg  <= rx_par_en_next;
      rx_par_odd_reg <= rx_par_odd_next;
    end
  end

  // ---------------- TX engine ----------------
  state_t tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0] tx_idx_reg, tx_idx_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic tx_par_reg, tx_par_next, tx_stop_idx_reg, tx_stop_idx_next;
  logic tx_bits7_reg, tx_bits7_next, tx_par_en_reg, tx_par_en_next, tx_stop2_reg, tx_stop2_next;
  logic tx_line_reg, tx_line_next, tx_load, tx_end, tx_busy;
  logic [7:0] tx_byte_fmt;

  assign tx_end      = (tx_cnt_reg == CNT_LAST);
  assign tx_busy     = (tx_state_reg != S_IDLE);
  assign tx_byte_fmt = ctrl_reg[0] ? {1'b0, tx_byte[6:0]} : tx_byte;

  always_comb begin
    tx_state_next    = tx_state_reg;
    tx_cnt_next      = tx_cnt_reg;
    tx_idx_next      = tx_idx_reg;
    tx_shift_next    = tx_shift_reg;
    tx_par_next      = tx_par_reg;
    tx_stop_idx_next = tx_stop_idx_reg;
    tx_bits7_next    = tx_bits7_reg;
    tx_par_en_next   = tx_par_en_reg;
    tx_stop2_next    = tx_stop2_reg;
    tx_load = 1'b0;
    tx_pop  = 1'b0;
    if (tick) begin
      if (tx_state_reg != S_IDLE) tx_cnt_next = tx_end ? '0 : tx_cnt_reg + 1'b1;
      case (tx_state_reg)
        S_IDLE:  tx_load = !tx_empty;
        S_START: if (tx_end) begin
          tx_state_next = S_DATA;
          tx_idx_next   = '0;
        end
        S_DATA: if (tx_end) begin
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          if (tx_idx_reg == (tx_bits7_reg ? 3'd6 : 3'd7)) begin
            tx_state_next    = tx_par_en_reg ? S_PARITY : S_STOP;
            tx_stop_idx_next = 1'b0;
          end else begin
            tx_idx_next = tx_idx_reg + 1'b1;
          end
        end
        S_PARITY: if (tx_end) begin
          tx_state_next    = S_STOP;
          tx_stop_idx_next = 1'b0;
        end
        S_STOP: if (tx_end) begin
          if (tx_stop2_reg && !tx_stop_idx_reg) tx_stop_idx_next = 1'b1;
          else if (!tx_empty) tx_load = 1'b1;
          else tx_state_next = S_IDLE;
        end
        default: tx_state_next = S_IDLE;
      endcase
      // Loading straight from STOP gives back-to-back frames with no idle gap.
      if (tx_load) begin
        tx_pop         = 1'b1;
        tx_state_next  = S_START;
        tx_cnt_next    = '0;
        tx_shift_next  = tx_byte;
        tx_bits7_next  = ctrl_reg[0];
        tx_par_en_next = ctrl_reg[1];
        tx_stop2_next  = ctrl_reg[3];
        tx_par_next    = (^tx_byte_fmt) ^ ctrl_reg[2];
      end
    end
    case (tx_state_reg)
      S_START:  tx_line_next = 1'b0;
      S_DATA:   tx_line_next = tx_shift_reg[0];
      S_PARITY: tx_line_next = tx_par_reg;
      default:  tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      tx_state_reg    <= S_IDLE;
      tx_cnt_reg      <= '0;
      tx_idx_reg      <= '0;
      tx_shift_reg    <= '0;
      tx_par_reg      <= 1'b0;
      tx_stop_idx_reg <= 1'b0;
      tx_bits7_reg    <= 1'b0;
      tx_par_en_reg   <= 1'b0;
      tx_stop2_reg    <= 1'b0;
      tx_line_reg     <= 1'b1;
    end else begin
      tx_state_reg    <= tx_state_next;
      tx_cnt_reg      <= tx_cnt_next;
      tx_idx_reg      <= tx_idx_next;
      tx_shift_reg    <= tx_shift_next;
      tx_par_reg      <= tx_par_next;
      tx_stop_idx_reg <= tx_stop_idx_next;
      tx_bits7_reg    <= tx_bits7_next;
      tx_par_en_reg   <= tx_par_en_next;
      tx_stop2_reg    <= tx_stop2_next;
      tx_line_reg     <= tx_line_next;
    end
  end

  assign uart_tx = tx_line_reg;

  // ---------------- sticky errors, read data, interrupts ----------------
  logic perr_reg, ferr_reg, rx_ovr_reg, tx_ovf_reg;
  logic rdata_reg, rx_irq_reg, tx_irq_reg, err_irq_reg;
  logic [31:0] rd_mux, rdata_q;
  logic [8:0] status_bits;

  assign status_bits = {tx_ovf_reg, rx_ovr_reg, ferr_reg, perr_reg,
                        rx_empty, rx_full, tx_busy, tx_empty, tx_full};

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      4'd0: if (!rx_empty) rd_mux = {24'b0, rx_mem[rx_rptr_reg[RX_AW-1:0]]};
      4'd1: rd_mux = {23'b0, status_bits};
      4'd2: rd_mux = {25'b0, ctrl_reg};
      4'd3: rd_mux = 32'(baud_div_reg);
      default: rd_mux = '0;
    endcase
  end

  // A new error in the same cycle as its W1C keeps the flag set.
  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      rx_ovr_reg  <= 1'b0;
      tx_ovf_reg  <= 1'b0;
      rdata_q     <= '0;
      rx_irq_reg  <= 1'b0;
      tx_irq_reg  <= 1'b0;
      err_irq_reg <= 1'b0;
    end else begin
      perr_reg    <= perr_evt   | (perr_reg   & ~(wr_status & xt_hb_wdata[5]));
      ferr_reg    <= ferr_evt   | (ferr_reg   & ~(wr_status & xt_hb_wdata[6]));
      rx_ovr_reg  <= rx_ovr_evt | (rx_ovr_reg & ~(wr_status & xt_hb_wdata[7]));
      tx_ovf_reg  <= tx_ovf_evt | (tx_ovf_reg & ~(wr_status & xt_hb_wdata[8]));
      if (sel_ren) rdata_q <= rd_mux;
      rx_irq_reg  <= ctrl_reg[4] & !rx_empty;
      tx_irq_reg  <= ctrl_reg[5] & tx_empty & !tx_busy;
      err_irq_reg <= ctrl_reg[6] & (perr_reg | ferr_reg | rx_ovr_reg | tx_ovf_reg);
    end
  end

  assign rdata_reg = 1'b0;
  assign rdata   = rdata_q;
  assign rx_irq  = rx_irq_reg;
  assign tx_irq  = tx_irq_reg;
  assign err_irq = err_irq_reg;

endmodule

// File: tb/tb_uart_ex_bus.sv
// Self-checking bench for uart_ex_bus: register table, TX/RX frames via scoreboards, corner sequences.
module tb_uart_ex_bus;
  localparam int BIT_CYC = 64;  // div=3, 16 samples per bit

  logic hb_clk = 1'b0;
  logic hb_rst_n = 1'b0;
  logic [31:0] xt_hb_raddr = '0, xt_hb_waddr = '0, xt_hb_wdata = '0;
  logic sel_ren = 1'b0, sel_wen = 1'b0;
  logic [31:0] rdata;
  logic rx_irq, tx_irq, err_irq;
  logic uart_rx = 1'b1;
  logic uart_tx;

  int total = 0;
  int bad = 0;
  logic tx_q [$];
  logic [7:0] rx_q [$];
  logic [31:0] rd;
  int low_len;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];

  uart_ex_bus dut (
    .hb_clk(hb_clk), .hb_rst_n(hb_rst_n),
    .xt_hb_raddr(xt_hb_raddr), .xt_hb_waddr(xt_hb_waddr), .xt_hb_wdata(xt_hb_wdata),
    .sel_ren(sel_ren), .sel_wen(sel_wen), .rdata(rdata),
    .rx_irq(rx_irq), .tx_irq(tx_irq), .err_irq(err_irq),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 hb_clk = ~hb_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [31:0] d);
    @(negedge hb_clk);
    xt_hb_waddr = {26'b0, idx, 2'b00};
    xt_hb_wdata = d;
    sel_wen = 1'b1;
    @(negedge hb_clk);
    sel_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [31:0] d);
    @(negedge hb_clk);
    xt_hb_raddr = {26'b0, idx, 2'b00};
    sel_ren = 1'b1;
    @(posedge hb_clk);
    #1;
    d = rdata;
    sel_ren = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge hb_clk);
    #1;
  endtask

  // Expected TX line levels, one entry per bit period.
  task automatic tx_expect(input logic [7:0] b, input bit b7, input bit pe, input bit po, input bit s2);
    logic p;
    p = po;
    tx_q.push_back(1'b0);
    for (int i = 0; i < (b7 ? 7 : 8); i++) begin
      tx_q.push_back(b[i]);
      p = p ^ b[i];
    end
    if (pe) tx_q.push_back(p);
    tx_q.push_back(1'b1);
    if (s2) tx_q.push_back(1'b1);
  endtask

  task automatic tx_capture(input string name, output int start_len);
    int waited;
    int nb;
    bit run;
    logic e;
    waited = 0;
    start_len = 0;
    while (uart_tx !== 1'b0 && waited < 3000) begin
      @(posedge hb_clk);
      #1;
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s start: got no start bit want falling edge", name);
      tx_q.delete();
      return;
    end
    nb = tx_q.size();
    run = 1'b1;
    for (int j = 0; j < nb * BIT_CYC; j++) begin
      if (run && uart_tx === 1'b0) start_len++;
      else run = 1'b0;
      if (j % BIT_CYC == BIT_CYC / 2) begin
        e = tx_q.pop_front();
        check($sformatf("%s bit%0d", name, j / BIT_CYC), 32'(uart_tx), 32'(e));
      end
      @(posedge hb_clk);
      #1;
    end
  endtask

  task automatic rx_bit(input logic v);
    @(negedge hb_clk);
    uart_rx = v;
    repeat (BIT_CYC - 1) @(negedge hb_clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input bit b7, input bit pe, input logic par_bit,
                         input bit s2, input logic stop_val);
    rx_bit(1'b0);
    for (int i = 0; i < (b7 ? 7 : 8); i++) rx_bit(b[i]);
    if (pe) rx_bit(par_bit);
    rx_bit(stop_val);
    if (s2) rx_bit(1'b1);
    @(negedge hb_clk);
    uart_rx = 1'b1;
  endtask

  task automatic rx_check(input string name);
    logic [7:0] e;
    bus_read(4'd0, rd);
    if (rx_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got 0x%08h want nothing queued", name, rd);
    end else begin
      e = rx_q.pop_front();
      check(name, rd, {24'b0, e});
    end
  endtask

  initial begin
    vecs[0] = '{4'd2, 32'hFFFF_FFFF, 32'h0000_007F};
    vecs[1] = '{4'd2, 32'h0000_0015, 32'h0000_0015};
    vecs[2] = '{4'd3, 32'hABCD_1234, 32'h0000_1234};
    vecs[3] = '{4'd3, 32'h0000_0003, 32'h0000_0003};
    vecs[4] = '{4'd5, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0012};

    // Reset state
    wait_cyc(3);
    check("reset uart_tx", 32'(uart_tx), 32'd1);
    check("reset irqs", {29'b0, rx_irq, tx_irq, err_irq}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    @(negedge hb_clk);
    hb_rst_n = 1'b1;
    bus_read(4'd1, rd); check("reset status", rd, 32'h12);
    bus_read(4'd2, rd); check("reset ctrl", rd, 32'h0);
    bus_read(4'd3, rd); check("reset baud", rd, 32'h0);

    // Register table
    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].idx, vecs[i].wdata);
      bus_read(vecs[i].idx, rd);
      check($sformatf("regvec%0d", i), rd, vecs[i].exp);
    end

    // TX 8N1 0x55 at div=3
    bus_write(4'd2, 32'h20);
    wait_cyc(3);
    check("tx_irq idle", 32'(tx_irq), 32'd1);
    bus_write(4'd0, 32'h55);
    tx_expect(8'h55, 0, 0, 0, 0);
    tx_capture("tx55", low_len);
    check("tx55 start len", 32'(low_len), 32'd64);
    wait_cyc(4);
    bus_read(4'd1, rd); check("tx55 status after", rd, 32'h12);
    check("tx55 tx_irq", 32'(tx_irq), 32'd1);

    // RX 8O2, good parity then bad parity
    bus_write(4'd2, 32'h5E);
    rx_q.push_back(8'hA3);
    rx_send(8'hA3, 0, 1, 1'b1, 1, 1'b1);
    wait_cyc(4);
    check("8o2 rx_irq", 32'(rx_irq), 32'd1);
    bus_read(4'd1, rd); check("8o2 status", rd, 32'h02);
    rx_check("8o2 data");
    check("8o2 err_irq", 32'(err_irq), 32'd0);
    rx_q.push_back(8'hA3);
    rx_send(8'hA3, 0, 1, 1'b0, 1, 1'b1);
    wait_cyc(4);
    bus_read(4'd1, rd); check("8o2 perr status", rd, 32'h22);
    check("8o2 perr err_irq", 32'(err_irq), 32'd1);
    rx_check("8o2 perr data");
    bus_write(4'd1, 32'h20);
    bus_read(4'd1, rd); check("perr w1c", rd, 32'h12);
    check("perr w1c err_irq", 32'(err_irq), 32'd0);

    // 7E1: RX 0xFF stores 0x7F; TX 0xC1
    bus_write(4'd2, 32'h03);
    rx_q.push_back(8'h7F);
    rx_send(8'hFF, 1, 1, 1'b1, 0, 1'b1);
    wait_cyc(4);
    rx_check("7e1 rx data");
    bus_read(4'd1, rd); check("7e1 status", rd, 32'h12);
    bus_write(4'd0, 32'hC1);
    tx_expect(8'hC1, 1, 1, 0, 0);
    tx_capture("txc1", low_len);
    check("txc1 start len", 32'(low_len), 32'd64);

    // RX overrun: nine frames into an eight-deep FIFO
    bus_write(4'd2, 32'h00);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rx_q.push_back(8'h10 + 8'(i));
      rx_send(8'h10 + 8'(i), 0, 0, 1'b0, 0, 1'b1);
    end
    wait_cyc(4);
    bus_read(4'd1, rd); check("ovr status", rd, 32'h8A);
    for (int i = 0; i < 8; i++) rx_check($sformatf("ovr data%0d", i));
    bus_read(4'd0, rd); check("ovr empty read", rd, 32'h0);
    bus_read(4'd1, rd); check("ovr status empty", rd, 32'h92);
    bus_write(4'd1, 32'h80);
    bus_read(4'd1, rd); check("ovr w1c", rd, 32'h12);

    // Short glitch is a false start; then a frame with a bad stop bit
    @(negedge hb_clk);
    uart_rx = 1'b0;
    repeat (16) @(negedge hb_clk);
    uart_rx = 1'b1;
    wait_cyc(200);
    bus_read(4'd1, rd); check("glitch status", rd, 32'h12);
    rx_q.push_back(8'h5A);
    rx_send(8'h5A, 0, 0, 1'b0, 0, 1'b0);
    wait_cyc(4);
    bus_read(4'd1, rd); check("ferr status", rd, 32'h42);
    rx_check("ferr data");
    bus_write(4'd1, 32'h40);

    // Reset in the middle of a frame, with a second byte still queued
    bus_write(4'd0, 32'h00);
    bus_write(4'd0, 32'h11);
    wait_cyc(150);
    check("midframe line", 32'(uart_tx), 32'd0);
    bus_read(4'd1, rd); check("midframe status", rd, 32'h14);
    @(posedge hb_clk);
    #3;
    hb_rst_n = 1'b0;
    #1;
    check("async reset uart_tx", 32'(uart_tx), 32'd1);
    wait_cyc(3);
    @(negedge hb_clk);
    hb_rst_n = 1'b1;
    bus_read(4'd1, rd); check("post reset status", rd, 32'h12);
    bus_read(4'd2, rd); check("post reset ctrl", rd, 32'h0);
    wait_cyc(100);
    check("post reset line", 32'(uart_tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
